phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 88 ++++++++
 tb/tb_phase_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-phase instruction cycle sequencer with single-step and stall
module phase_sequencer #(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 8,
    localparam int PHASE_W   = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic                  stall,
    output logic [PHASE_W-1:0]    phase_idx,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  phase_out,
    output logic                  instr_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic               advance;
    logic               wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        done_d  = 1'b0;
        advance = (state_q == ST_RUN) && !stall;
        wrap    = advance && (phase_q == LAST_PHASE);

        if (advance) begin
            phase_d = wrap ? '0 : phase_q + PHASE_W'(1);
        end
        if (wrap) begin
            count_d = count_q + CNT_W'(1);
            done_d  = 1'b1;
        end

        // Leaving RUN is only possible at a cycle boundary, so a cycle is never truncated
        case (state_q)
            ST_IDLE: begin
                if (enable && (!step_mode || step_req)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap && (!enable || step_mode)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase_idx    = phase_q;
    assign phase_onehot = NUM_PHASES'(1) << phase_q;
    assign phase_out    = phase_q[0];
    assign instr_done   = done_q;
    assign busy         = (state_q == ST_RUN);
    assign cycle_count  = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset, enable, step_mode, step_req, stall;
    logic [1:0] phase_idx;
    logic [3:0] phase_onehot;
    logic       phase_out, instr_done, busy;
    logic [7:0] cycle_count;

    logic       b_reset, b_enable;
    logic [0:0] b_phase_idx;
    logic [1:0] b_phase_onehot;
    logic       b_phase_out, b_instr_done, b_busy;
    logic [1:0] b_cycle_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .step_mode(step_mode),
        .step_req(step_req), .stall(stall), .phase_idx(phase_idx),
        .phase_onehot(phase_onehot), .phase_out(phase_out),
        .instr_done(instr_done), .busy(busy), .cycle_count(cycle_count)
    );

    phase_sequencer #(.NUM_PHASES(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .step_mode(1'b0),
        .step_req(1'b0), .stall(1'b0), .phase_idx(b_phase_idx),
        .phase_onehot(b_phase_onehot), .phase_out(b_phase_out),
        .instr_done(b_instr_done), .busy(b_busy), .cycle_count(b_cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int ph, input int done, input int cnt, input int bsy);
        logic [3:0] oh;
        logic [1:0] ph2;
        ph2 = ph[1:0];
        oh  = 4'b0001 << ph2;
        chk({tag, ".phase"},  32'(phase_idx), 32'(ph));
        chk({tag, ".onehot"}, 32'(phase_onehot), 32'(oh));
        chk({tag, ".pout"},   32'(phase_out), 32'(ph2[0]));
        chk({tag, ".done"},   32'(instr_done), 32'(done));
        chk({tag, ".count"},  32'(cycle_count), 32'(cnt));
        chk({tag, ".busy"},   32'(busy), 32'(bsy));
    endtask

    int fr_ph[9]   = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int fr_dn[9]   = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int fr_cn[9]   = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    int b_ph[10]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int b_dn[10]   = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int b_cn[10]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        reset = 1'b1; enable = 1'b0; step_mode = 1'b0; step_req = 1'b0; stall = 1'b0;
        b_reset = 1'b1; b_enable = 1'b0;
        tick();
        chk_a("reset", 0, 0, 0, 0);

        // free-run from IDLE: first edge only enters RUN
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_a($sformatf("free%0d", i), fr_ph[i], fr_dn[i], fr_cn[i], 1);
        end

        // stall on the last phase suppresses wrap
        tick(); tick(); tick();
        chk_a("pre_stall", 3, 0, 2, 1);
        stall = 1'b1;
        tick(); chk_a("stall0", 3, 0, 2, 1);
        tick(); chk_a("stall1", 3, 0, 2, 1);
        stall = 1'b0;
        tick(); chk_a("unstall", 0, 1, 3, 1);
        tick(); chk_a("ph1", 1, 0, 3, 1);

        // drop enable mid-cycle: cycle completes, then parks
        enable = 1'b0;
        tick(); chk_a("drain2", 2, 0, 3, 1);
        tick(); chk_a("drain3", 3, 0, 3, 1);
        tick(); chk_a("drain_wrap", 0, 1, 4, 0);
        tick(); chk_a("parked", 0, 0, 4, 0);
        stall = 1'b1;
        tick(); chk_a("idle_stall", 0, 0, 4, 0);
        stall = 1'b0;

        // single step
        step_mode = 1'b1; enable = 1'b1;
        tick(); chk_a("step_wait", 0, 0, 4, 0);
        step_req = 1'b1;
        tick(); chk_a("step_go", 0, 0, 4, 1);
        step_req = 1'b0;
        tick(); chk_a("step1", 1, 0, 4, 1);
        tick(); chk_a("step2", 2, 0, 4, 1);
        step_req = 1'b1;
        tick(); chk_a("step3", 3, 0, 4, 1);
        step_req = 1'b0;
        tick(); chk_a("step_wrap", 0, 1, 5, 0);
        tick(); chk_a("step_noqueue", 0, 0, 5, 0);

        // reset mid-cycle with stall asserted
        step_mode = 1'b0;
        tick(); chk_a("rs_go", 0, 0, 5, 1);
        tick(); chk_a("rs1", 1, 0, 5, 1);
        tick(); chk_a("rs2", 2, 0, 5, 1);
        reset = 1'b1; stall = 1'b1;
        tick(); chk_a("rs_abort", 0, 0, 0, 0);
        reset = 1'b0; stall = 1'b0; enable = 1'b0;
        tick(); chk_a("rs_after", 0, 0, 0, 0);

        // two-phase legacy configuration, counter wrap 3 -> 0
        b_reset = 1'b0; b_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("b%0d.phase", i), 32'(b_phase_idx), 32'(b_ph[i]));
            chk($sformatf("b%0d.pout", i),  32'(b_phase_out), 32'(b_ph[i]));
            chk($sformatf("b%0d.onehot", i), 32'(b_phase_onehot), (b_ph[i] != 0) ? 32'd2 : 32'd1);
            chk($sformatf("b%0d.done", i),  32'(b_instr_done), 32'(b_dn[i]));
            chk($sformatf("b%0d.count", i), 32'(b_cycle_count), 32'(b_cn[i]));
            chk($sformatf("b%0d.busy", i),  32'(b_busy), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
